// File: rtl/bcd_counter_display_if.sv
// Control and display bundle for the multi-digit BCD counter.
// The master drives count controls; the slave returns count and display pins.
interface bcd_counter_display_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  overflow;
    logic [6:0]            y;
    logic [DIGITS-1:0]     control;

    modport master (
        output en, up, load, load_val,
        input  count, overflow, y, control
    );

    modport slave (
        input  en, up, load, load_val,
        output count, overflow, y, control
    );
endinterface

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with tick prescaler and a
// multiplexed active-low 7-segment display driver.
module bcd_counter_display #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter int BLANK_LZ = 0
) (
    input  logic clk,
    input  logic rst,
    bcd_counter_display_if.slave bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int LW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NB = 4 * DIGITS;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [LW-1:0] SEL_LAST  = LW'(DIGITS - 1);

    logic [TW-1:0]     r_tick_cnt;
    logic [SW-1:0]     r_scan_cnt;
    logic [LW-1:0]     r_sel;
    logic [NB-1:0]     r_count;
    logic              r_overflow;
    logic [6:0]        r_y;
    logic [DIGITS-1:0] r_control;

    logic              w_tick;
    logic              w_scan;
    logic [NB-1:0]     w_load_clean;
    logic [NB-1:0]     w_inc;
    logic [NB-1:0]     w_dec;
    logic              w_inc_wrap;
    logic              w_dec_wrap;
    logic [3:0]        w_digit;
    logic              w_sel_lz;
    logic              w_blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign w_scan = (r_scan_cnt == SCAN_LAST);

    // Free-running count-tick prescaler, independent of en and load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tick_cnt <= '0;
        else     r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
    end

    // Free-running display-scan prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_scan_cnt <= '0;
        else     r_scan_cnt <= w_scan ? '0 : r_scan_cnt + SW'(1);
    end

    // Ripple increment/decrement candidates and sanitised load value
    always_comb begin : bcd_step
        logic       v_c;
        logic       v_b;
        logic [3:0] v_d;
        logic [3:0] v_n;
        v_c          = 1'b1;
        v_b          = 1'b1;
        v_d          = '0;
        v_n          = '0;
        w_inc        = '0;
        w_dec        = '0;
        w_load_clean = '0;
        for (int k = 0; k < DIGITS; k++) begin
            v_d = r_count[4*k +: 4];
            if (!v_c)
                w_inc[4*k +: 4] = v_d;
            else if (v_d == 4'd9)
                w_inc[4*k +: 4] = 4'd0;
            else begin
                w_inc[4*k +: 4] = v_d + 4'd1;
                v_c = 1'b0;
            end
            if (!v_b)
                w_dec[4*k +: 4] = v_d;
            else if (v_d == 4'd0)
                w_dec[4*k +: 4] = 4'd9;
            else begin
                w_dec[4*k +: 4] = v_d - 4'd1;
                v_b = 1'b0;
            end
            v_n = bus.load_val[4*k +: 4];
            w_load_clean[4*k +: 4] = (v_n > 4'd9) ? 4'd0 : v_n;
        end
        w_inc_wrap = v_c;
        w_dec_wrap = v_b;
    end

    // Count register: load beats tick, wrap raises a one-cycle overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (bus.load) begin
                r_count <= w_load_clean;
            end else if (w_tick && bus.en) begin
                if (bus.up) begin
                    r_count    <= w_inc;
                    r_overflow <= w_inc_wrap;
                end else begin
                    r_count    <= w_dec;
                    r_overflow <= w_dec_wrap;
                end
            end
        end
    end

    // Active digit advances on each scan step and wraps to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sel <= '0;
        else if (w_scan)
            r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + LW'(1);
    end

    // Pick the scanned digit and whether it and all higher digits are zero
    always_comb begin : disp_sel
        logic v_z;
        v_z      = 1'b1;
        w_digit  = '0;
        w_sel_lz = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            v_z = v_z & (r_count[4*k +: 4] == 4'd0);
            if (LW'(k) == r_sel) begin
                w_digit  = r_count[4*k +: 4];
                w_sel_lz = v_z;
            end
        end
    end

    assign w_blank = (BLANK_LZ != 0) && (r_sel != '0) && w_sel_lz;

    // Registered anode select and segment pattern
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_control <= ~DIGITS'(1);
            r_y       <= 7'b1000000;
        end else begin
            r_control <= ~(DIGITS'(1) << r_sel);
            r_y       <= w_blank ? 7'b1111111 : seg7(w_digit);
        end
    end

    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.y        = r_y;
    assign bus.control  = r_control;

endmodule
